// File: rtl/mem_request_arbiter.sv
// Round-robin arbiter serving per-thread memory requests from one single-ported store.
// Define MEM_ARB_STATS_EN to build the saturating contention counter (conflict_count).
module mem_request_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int MEM_SIZE   = 32,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            req_valid,
  output logic [NUM_PORTS-1:0]            req_ready,
  input  logic [NUM_PORTS-1:0]            req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]            rsp_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_data,
  output logic [15:0]                     conflict_count,
  output logic [DATA_WIDTH-1:0]           debug_data_0,
  output logic [DATA_WIDTH-1:0]           debug_data_16
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  logic [PTR_W-1:0]      rr_ptr_reg, rr_ptr_next;
  logic [NUM_PORTS-1:0]  grant;
  logic                  gnt_found;
  logic [PTR_W-1:0]      gnt_idx;
  logic                  gnt_write;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_wdata;
  logic                  in_range;
  logic [IDX_W-1:0]      mem_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [DATA_WIDTH-1:0]           mem_reg [MEM_SIZE];
  logic [NUM_PORTS-1:0]            rsp_valid_reg;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_data_reg;

  // First valid port at or after rr_ptr, with wrap-around.
  always_comb begin
    grant     = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!gnt_found && req_valid[PTR_W'((int'(rr_ptr_reg) + k) % NUM_PORTS)]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'((int'(rr_ptr_reg) + k) % NUM_PORTS);
      end
    end
    if (gnt_found) grant[gnt_idx] = 1'b1;
    req_ready = reset ? grant : '0;
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (gnt_found)
      rr_ptr_next = (gnt_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
  end

  assign gnt_write = req_write[gnt_idx];
  assign gnt_addr  = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign gnt_wdata = req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  assign mem_idx   = gnt_addr[IDX_W-1:0];

  generate
    if (MEM_SIZE >= (1 << ADDR_WIDTH)) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_part_range
      assign in_range = (gnt_addr < ADDR_WIDTH'(MEM_SIZE));
    end
  endgenerate

  assign rd_word = in_range ? mem_reg[mem_idx] : '0;

  // Storage is register-based so the whole array can be cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_SIZE; i++) mem_reg[i] <= '0;
    end else if (gnt_found && gnt_write && in_range) begin
      mem_reg[mem_idx] <= gnt_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_reg    <= '0;
      rsp_valid_reg <= '0;
      rsp_data_reg  <= '0;
    end else begin
      rr_ptr_reg    <= rr_ptr_next;
      rsp_valid_reg <= '0;
      if (gnt_found) begin
        rsp_valid_reg[gnt_idx] <= 1'b1;
        rsp_data_reg[gnt_idx*DATA_WIDTH +: DATA_WIDTH] <= gnt_write ? gnt_wdata : rd_word;
      end
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] conflict_count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      conflict_count_reg <= '0;
    else if (($countones(req_valid) >= 2) && (conflict_count_reg != 16'hFFFF))
      conflict_count_reg <= conflict_count_reg + 16'd1;
  end

  assign conflict_count = conflict_count_reg;
`else
  assign conflict_count = 16'h0000;
`endif

  assign debug_data_0 = mem_reg[0];

  generate
    if (MEM_SIZE > 16) begin : g_dbg16
      assign debug_data_16 = mem_reg[16];
    end else begin : g_no_dbg16
      assign debug_data_16 = '0;
    end
  endgenerate

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Vector-table bench for mem_request_arbiter (4 ports, 32 words, 6-bit addresses so
// that out-of-range addresses are representable), plus reset and saturation sequences.
module tb_mem_request_arbiter;

  localparam int NP = 4;
  localparam int DW = 8;
  localparam int AW = 6;

`ifdef MEM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     req_valid;
  logic [NP-1:0]     req_ready;
  logic [NP-1:0]     req_write;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*DW-1:0]  req_wdata;
  logic [NP-1:0]     rsp_valid;
  logic [NP*DW-1:0]  rsp_data;
  logic [15:0]       conflict_count;
  logic [DW-1:0]     debug_data_0;
  logic [DW-1:0]     debug_data_16;

  int n_cmp = 0;
  int n_bad = 0;

  mem_request_arbiter #(
    .NUM_PORTS(NP), .MEM_SIZE(32), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .conflict_count(conflict_count),
    .debug_data_0(debug_data_0), .debug_data_16(debug_data_16)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0]    valid;
    logic [NP-1:0]    write;
    logic [NP*AW-1:0] addr;
    logic [NP*DW-1:0] wdata;
    logic [NP-1:0]    exp_ready;
    logic [NP-1:0]    exp_rsp;
    logic [DW-1:0]    exp_data;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] conf_exp(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  initial begin
    // addr/wdata packed as {port3, port2, port1, port0}
    tbl[0]  = '{4'b0100, 4'b0100, {6'd0, 6'd5, 6'd0, 6'd0},  {8'h00, 8'hA7, 8'h00, 8'h00}, 4'b0100, 4'b0100, 8'hA7};
    tbl[1]  = '{4'b0100, 4'b0000, {6'd0, 6'd5, 6'd0, 6'd0},  32'h0,                        4'b0100, 4'b0100, 8'hA7};
    tbl[2]  = '{4'b0001, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd31}, {8'h00, 8'h00, 8'h00, 8'h3C}, 4'b0001, 4'b0001, 8'h3C};
    tbl[3]  = '{4'b0001, 4'b0000, {6'd0, 6'd0, 6'd0, 6'd31}, 32'h0,                        4'b0001, 4'b0001, 8'h3C};
    tbl[4]  = '{4'b0010, 4'b0010, {6'd0, 6'd0, 6'd40, 6'd0}, {8'h00, 8'h00, 8'hFF, 8'h00}, 4'b0010, 4'b0010, 8'hFF};
    tbl[5]  = '{4'b0010, 4'b0000, {6'd0, 6'd0, 6'd40, 6'd0}, 32'h0,                        4'b0010, 4'b0010, 8'h00};
    tbl[6]  = '{4'b0010, 4'b0000, {6'd0, 6'd0, 6'd8, 6'd0},  32'h0,                        4'b0010, 4'b0010, 8'h00};
    tbl[7]  = '{4'b1010, 4'b0000, {6'd31, 6'd0, 6'd5, 6'd0}, 32'h0,                        4'b1000, 4'b1000, 8'h3C};
    tbl[8]  = '{4'b0010, 4'b0000, {6'd31, 6'd0, 6'd5, 6'd0}, 32'h0,                        4'b0010, 4'b0010, 8'hA7};
    tbl[9]  = '{4'b0000, 4'b0000, {6'd0, 6'd0, 6'd0, 6'd0},  32'h0,                        4'b0000, 4'b0000, 8'h00};
    tbl[10] = '{4'b1001, 4'b1000, {6'd0, 6'd0, 6'd0, 6'd0},  {8'h5A, 8'h00, 8'h00, 8'h00}, 4'b1000, 4'b1000, 8'h5A};
    tbl[11] = '{4'b1001, 4'b0000, {6'd5, 6'd0, 6'd0, 6'd0},  32'h0,                        4'b0001, 4'b0001, 8'h5A};
    tbl[12] = '{4'b1000, 4'b0000, {6'd5, 6'd0, 6'd0, 6'd0},  32'h0,                        4'b1000, 4'b1000, 8'hA7};
    tbl[13] = '{4'b1000, 4'b0000, {6'd0, 6'd0, 6'd0, 6'd0},  32'h0,                        4'b1000, 4'b1000, 8'h5A};

    reset     = 1'b0;
    req_valid = 4'hF;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 32'(req_ready), 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_data", rsp_data, 32'h0);
    check("reset_conflict", 32'(conflict_count), 32'h0);
    check("reset_dbg0", 32'(debug_data_0), 32'h0);

    // All four ports valid from reset release: grants rotate 0,1,2,3,0.
    reset = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr_ready_%0d", i), 32'(req_ready), 32'(4'b0001 << (i % 4)));
      @(posedge clk);
      #1;
      check($sformatf("rr_rsp_%0d", i), 32'(rsp_valid), 32'(4'b0001 << (i % 4)));
      $display("rr cycle %0d: ready->rsp %b", i, rsp_valid);
    end
    req_valid = '0;
    check("rr_conflict5", 32'(conflict_count), conf_exp(5));

    for (int i = 0; i < 14; i++) begin
      req_valid = tbl[i].valid;
      req_write = tbl[i].write;
      req_addr  = tbl[i].addr;
      req_wdata = tbl[i].wdata;
      #1;
      check($sformatf("v%0d_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].exp_rsp));
      for (int p = 0; p < NP; p++)
        if (tbl[i].exp_rsp[p])
          check($sformatf("v%0d_rsp_data%0d", i, p), 32'(rsp_data[p*DW +: DW]), 32'(tbl[i].exp_data));
      $display("vec %0d: valid=%b ready=%b rsp_valid=%b rsp_data=%h", i, tbl[i].valid, req_ready, rsp_valid, rsp_data);
    end
    req_valid = '0;
    req_write = '0;
    check("dbg0_after_table", 32'(debug_data_0), 32'h5A);
    check("dbg16_after_table", 32'(debug_data_16), 32'h0);
    check("conflict_after_table", 32'(conflict_count), conf_exp(8));

    // Write addr 16, then reset arrives while a read of addr 16 is waiting.
    req_valid = 4'b0100;
    req_write = 4'b0100;
    req_addr  = {6'd0, 6'd16, 6'd0, 6'd0};
    req_wdata = {8'h00, 8'h11, 8'h00, 8'h00};
    #1;
    check("w16_ready", 32'(req_ready), 32'h4);
    @(posedge clk);
    #1;
    check("w16_rsp", 32'(rsp_valid), 32'h4);
    check("dbg16_before_reset", 32'(debug_data_16), 32'h11);
    $display("write addr16: rsp_valid=%b dbg16=%h", rsp_valid, debug_data_16);
    req_write = '0;
    #1;
    check("r16_ready", 32'(req_ready), 32'h4);
    #2;
    reset = 1'b0;
    #1;
    check("midreset_ready", 32'(req_ready), 32'h0);
    check("dbg16_after_reset", 32'(debug_data_16), 32'h0);
    check("midreset_rsp", 32'(rsp_valid), 32'h0);
    req_valid = 4'hF;
    req_addr  = {6'd16, 6'd16, 6'd16, 6'd16};
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("in_reset_rsp_%0d", i), 32'(rsp_valid), 32'h0);
    end
    reset = 1'b1;
    #1;
    check("post_reset_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    check("post_reset_rsp", 32'(rsp_valid), 32'h1);
    check("post_reset_data", rsp_data, 32'h0);
    check("post_reset_conflict", 32'(conflict_count), conf_exp(1));
    $display("after reset release: rsp_valid=%b rsp_data=%h", rsp_valid, rsp_data);

    // Saturation: keep two ports contending for well over 65535 cycles.
    req_valid = 4'b0011;
    repeat (65533) @(posedge clk);
    #1;
    check("conflict_65534", 32'(conflict_count), conf_exp(65534));
    @(posedge clk);
    #1;
    check("conflict_65535", 32'(conflict_count), conf_exp(65535));
    repeat (4500) @(posedge clk);
    #1;
    check("conflict_saturated", 32'(conflict_count), conf_exp(65535));
    $display("saturation: conflict_count=%h", conflict_count);
    req_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
